mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/mem_wb_stage_if.sv | 39 +++
 rtl/mem_wb_stage_load_align.sv | 40 ++++
 rtl/mem_wb_stage.sv | 99 +++++++++
 tb/tb_mem_wb_stage.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: load opcodes, WB data-hold FSM states and a
// load-decode helper used by both the MEM and WB stages.
package lsu_pkg;

  // Load opcodes carried on lsu_op
  localparam logic [3:0] LD_B  = 4'b0000;
  localparam logic [3:0] LD_H  = 4'b0001;
  localparam logic [3:0] LD_W  = 4'b0010;
  localparam logic [3:0] LD_BU = 4'b1000;
  localparam logic [3:0] LD_HU = 4'b1001;

  // EMPTY: nothing in WB; LIVE: load data comes straight off the SRAM bus;
  // HELD: load data comes from the hold buffer captured during a stall
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LIVE  = 2'd1,
    ST_HELD  = 2'd2
  } wb_state_e;

  // True only for a real memory read with a recognised load opcode
  function automatic logic is_load(input logic ram_rd_en, input logic [3:0] op);
    return ram_rd_en && (op == LD_B || op == LD_H || op == LD_W ||
                         op == LD_BU || op == LD_HU);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB bundle: pipeline control, MEM-stage instruction fields, SRAM
// read data, and the WB-stage results and register-file write port.
interface mem_wb_stage_if;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_rw_en;
  logic [4:0]  in_rw_addr;
  logic [31:0] in_rw_data;
  logic        in_ram_rd_en;
  logic [3:0]  in_lsu_op;
  logic [15:0] in_except_type;
  logic [31:0] sram_rd_data;

  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic [15:0] wb_except_type;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] retire_cnt;

  modport master (
    output stall, flush, in_valid, in_pc, in_inst, in_rw_en, in_rw_addr,
           in_rw_data, in_ram_rd_en, in_lsu_op, in_except_type, sram_rd_data,
    input  wb_valid, wb_pc, wb_inst, wb_except_type, rf_we, rf_waddr,
           rf_wdata, retire_cnt
  );

  modport slave (
    input  stall, flush, in_valid, in_pc, in_inst, in_rw_en, in_rw_addr,
           in_rw_data, in_ram_rd_en, in_lsu_op, in_except_type, sram_rd_data,
    output wb_valid, wb_pc, wb_inst, wb_except_type, rf_we, rf_waddr,
           rf_wdata, retire_cnt
  );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load extraction: picks the byte/half/word addressed by the low address
// bits out of an aligned SRAM word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [3:0]  lsu_op,
  output logic [31:0] result
);

  logic [7:0]  lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = lane[offset];
  // Only offsets 0 and 2 are legal for halfwords; bit 1 selects the half
  assign sel_half = offset[1] ? word[31:16] : word[15:0];

  // Extend the selected field according to the opcode
  always_comb begin
    result = word;
    case (lsu_op)
      LD_B:    result = {{24{sel_byte[7]}}, sel_byte};
      LD_BU:   result = {24'd0, sel_byte};
      LD_H:    result = {{16{sel_half[15]}}, sel_half};
      LD_HU:   result = {16'd0, sel_half};
      LD_W:    result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Write-back pipeline stage: registers the MEM-stage instruction, keeps
// load data alive across stalls via a one-word hold buffer, drives the
// register-file write port and counts retired instructions.
module mem_wb_stage
  import lsu_pkg::*;
(
  input logic          clk,
  input logic          rst,
  mem_wb_stage_if.slave bus
);

  wb_state_e   state_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic        rw_en_reg;
  logic [4:0]  rw_addr_reg;
  logic [31:0] rw_data_reg;
  logic        ram_rd_en_reg;
  logic [3:0]  lsu_op_reg;
  logic [15:0] except_reg;
  logic [31:0] hold_reg;
  logic [31:0] retire_cnt_reg;

  logic        wb_valid;
  logic        retire;
  logic [31:0] load_word;
  logic [31:0] load_result;

  assign wb_valid  = (state_reg != ST_EMPTY);
  assign retire    = wb_valid & ~bus.stall;
  // SRAM data is only valid in the first WB cycle; afterwards use the copy
  assign load_word = (state_reg == ST_HELD) ? hold_reg : bus.sram_rd_data;

  load_align u_load_align (
    .word   (load_word),
    .offset (rw_data_reg[1:0]),
    .lsu_op (lsu_op_reg),
    .result (load_result)
  );

  // Data-hold FSM and WB instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      pc_reg        <= '0;
      inst_reg      <= '0;
      rw_en_reg     <= 1'b0;
      rw_addr_reg   <= '0;
      rw_data_reg   <= '0;
      ram_rd_en_reg <= 1'b0;
      lsu_op_reg    <= '0;
      except_reg    <= '0;
      hold_reg      <= '0;
    end else if (bus.flush) begin
      state_reg <= ST_EMPTY;
      hold_reg  <= '0;
    end else if (bus.stall) begin
      // Grab the SRAM word exactly once, on the first stalled cycle
      if (state_reg == ST_LIVE) begin
        hold_reg  <= bus.sram_rd_data;
        state_reg <= ST_HELD;
      end
    end else if (bus.in_valid) begin
      state_reg     <= ST_LIVE;
      pc_reg        <= bus.in_pc;
      inst_reg      <= bus.in_inst;
      rw_en_reg     <= bus.in_rw_en;
      rw_addr_reg   <= bus.in_rw_addr;
      rw_data_reg   <= bus.in_rw_data;
      ram_rd_en_reg <= bus.in_ram_rd_en;
      lsu_op_reg    <= bus.in_lsu_op;
      except_reg    <= bus.in_except_type;
    end else begin
      state_reg <= ST_EMPTY;
    end
  end

  // Retirement counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_reg <= '0;
    end else if (retire) begin
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

  assign bus.wb_valid       = wb_valid;
  assign bus.wb_pc          = pc_reg;
  assign bus.wb_inst        = inst_reg;
  assign bus.wb_except_type = except_reg;
  assign bus.retire_cnt     = retire_cnt_reg;
  assign bus.rf_waddr       = rw_addr_reg;
  // Excepting instructions and writes to x0 never reach the register file
  assign bus.rf_we          = retire & rw_en_reg & (except_reg == 16'd0) &
                              (rw_addr_reg != 5'd0);
  assign bus.rf_wdata       = is_load(ram_rd_en_reg, lsu_op_reg) ? load_result
                                                                 : rw_data_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table-driven back-to-back
// instructions with a scoreboard queue, plus stall/flush/reset sequences.
module tb_mem_wb_stage;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int we_base;
  logic [31:0] model_cnt;

  typedef struct {
    logic        rw_en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rd_en;
    logic [3:0]  op;
    logic [15:0] exc;
    logic [31:0] sram;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [15:0] exc;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  exp_t exp_q [$];

  // Count register-file write pulses as seen at each active edge
  always @(posedge clk) if (bus.rf_we) we_count++;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_in();
    bus.in_valid       = 1'b0;
    bus.in_pc          = '0;
    bus.in_inst        = '0;
    bus.in_rw_en       = 1'b0;
    bus.in_rw_addr     = '0;
    bus.in_rw_data     = '0;
    bus.in_ram_rd_en   = 1'b0;
    bus.in_lsu_op      = '0;
    bus.in_except_type = '0;
  endtask

  task automatic drive(input logic rw_en, input logic [4:0] addr, input logic [31:0] data,
                       input logic rd_en, input logic [3:0] op, input logic [15:0] exc,
                       input logic [31:0] pc);
    bus.in_valid       = 1'b1;
    bus.in_pc          = pc;
    bus.in_inst        = pc ^ 32'hA5A5_0000;
    bus.in_rw_en       = rw_en;
    bus.in_rw_addr     = addr;
    bus.in_rw_data     = data;
    bus.in_ram_rd_en   = rd_en;
    bus.in_lsu_op      = op;
    bus.in_except_type = exc;
  endtask

  // Compare the instruction currently in WB against the scoreboard head
  task automatic observe();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty actual=wb_valid:%b required=queued entry", bus.wb_valid);
      return;
    end
    checks--;
    e = exp_q.pop_front();
    check("tbl_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("tbl_wb_pc", bus.wb_pc, e.pc);
    check("tbl_wb_inst", bus.wb_inst, e.pc ^ 32'hA5A5_0000);
    check("tbl_except", 32'(bus.wb_except_type), 32'(e.exc));
    check("tbl_waddr", 32'(bus.rf_waddr), 32'(e.addr));
    check("tbl_rf_we", 32'(bus.rf_we), 32'(e.we));
    if (e.we) check("tbl_wdata", bus.rf_wdata, e.wdata);
    check("tbl_retire_cnt", bus.retire_cnt, model_cnt);
    model_cnt = model_cnt + 32'd1;
    $display("txn pc=%h waddr=%0d we=%b wdata=%h cnt=%h",
             bus.wb_pc, bus.rf_waddr, bus.rf_we, bus.rf_wdata, bus.retire_cnt);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd1,  32'h0000_0103, 1'b1, LD_B,    16'h0000, 32'h80FF_1234, 1'b1, 32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 5'd2,  32'h0000_0203, 1'b1, LD_BU,   16'h0000, 32'h80FF_1234, 1'b1, 32'h0000_0080};
    vecs[2]  = '{1'b1, 5'd3,  32'h0000_0200, 1'b1, LD_B,    16'h0000, 32'h80FF_1234, 1'b1, 32'h0000_0034};
    vecs[3]  = '{1'b1, 5'd4,  32'h0000_0302, 1'b1, LD_B,    16'h0000, 32'h80FF_1234, 1'b1, 32'hFFFF_FFFF};
    vecs[4]  = '{1'b1, 5'd5,  32'h0000_0402, 1'b1, LD_H,    16'h0000, 32'h80FF_1234, 1'b1, 32'hFFFF_80FF};
    vecs[5]  = '{1'b1, 5'd6,  32'h0000_0500, 1'b1, LD_HU,   16'h0000, 32'h80FF_1234, 1'b1, 32'h0000_1234};
    vecs[6]  = '{1'b1, 5'd7,  32'h0000_0500, 1'b1, LD_H,    16'h0000, 32'h0000_ABCD, 1'b1, 32'hFFFF_ABCD};
    vecs[7]  = '{1'b1, 5'd8,  32'h0000_0600, 1'b1, LD_W,    16'h0000, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 5'd9,  32'h1234_5678, 1'b0, LD_B,    16'h0000, 32'h80FF_1234, 1'b1, 32'h1234_5678};
    vecs[9]  = '{1'b1, 5'd0,  32'h0000_0600, 1'b1, LD_W,    16'h0000, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[10] = '{1'b1, 5'd10, 32'h0000_0700, 1'b1, LD_W,    16'h0001, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[11] = '{1'b1, 5'd11, 32'h0000_0801, 1'b1, LD_H,    16'h0010, 32'h80FF_1234, 1'b0, 32'h0000_0000};
    vecs[12] = '{1'b1, 5'd12, 32'h0000_0ABC, 1'b1, 4'b0011, 16'h0000, 32'h80FF_1234, 1'b1, 32'h0000_0ABC};
    vecs[13] = '{1'b0, 5'd13, 32'h0000_0005, 1'b0, LD_B,    16'h0000, 32'h80FF_1234, 1'b0, 32'h0000_0000};
    vecs[14] = '{1'b1, 5'd14, 32'h0000_0901, 1'b1, LD_BU,   16'h0000, 32'h80FF_1234, 1'b1, 32'h0000_0012};

    // ---- reset state
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.sram_rd_data = 32'h5A5A_5A5A;
    idle_in();
    model_cnt = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rst_rf_wdata", bus.rf_wdata, 32'd0);
    check("rst_wb_pc", bus.wb_pc, 32'd0);
    check("rst_wb_inst", bus.wb_inst, 32'd0);
    check("rst_except", 32'(bus.wb_except_type), 32'd0);
    check("rst_retire_cnt", bus.retire_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- table: back-to-back instructions, SRAM data one cycle behind
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) bus.sram_rd_data = vecs[i-1].sram;
      if (i < NV) begin
        exp_t e;
        e.pc    = 32'h1000 + 32'(4 * i);
        e.addr  = vecs[i].addr;
        e.exc   = vecs[i].exc;
        e.we    = vecs[i].exp_we;
        e.wdata = vecs[i].exp_wdata;
        drive(vecs[i].rw_en, vecs[i].addr, vecs[i].data, vecs[i].rd_en,
              vecs[i].op, vecs[i].exc, e.pc);
        exp_q.push_back(e);
      end else begin
        idle_in();
      end
      #1;
      if (i > 0) observe();
    end
    @(negedge clk);
    #1;
    check("drain_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("drain_retire_cnt", bus.retire_cnt, model_cnt);

    // ---- LD.HU held across a 3-cycle stall while SRAM bus changes
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h0000_0102, 1'b1, LD_HU, 16'h0, 32'h2000);
    bus.sram_rd_data = 32'h0;
    we_base = we_count;
    @(negedge clk);
    idle_in();
    bus.stall = 1'b1;
    bus.sram_rd_data = 32'h80FF_1234;
    #1;
    check("stall_rf_we", 32'(bus.rf_we), 32'd0);
    check("stall_wb_valid", 32'(bus.wb_valid), 32'd1);
    @(negedge clk);
    bus.sram_rd_data = 32'hDEAD_BEEF;
    #1;
    check("held_wdata", bus.rf_wdata, 32'h0000_80FF);
    @(negedge clk);
    #1;
    check("stall_retire_cnt", bus.retire_cnt, model_cnt);
    @(negedge clk);
    bus.stall = 1'b0;
    #1;
    check("release_rf_we", 32'(bus.rf_we), 32'd1);
    check("release_wdata", bus.rf_wdata, 32'h0000_80FF);
    check("release_waddr", 32'(bus.rf_waddr), 32'd7);
    @(negedge clk);
    #1;
    model_cnt = model_cnt + 32'd1;
    check("release_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("release_retire_cnt", bus.retire_cnt, model_cnt);
    check("release_we_pulses", 32'(we_count - we_base), 32'd1);
    $display("txn stalled LD.HU wdata=%h cnt=%h", bus.rf_wdata, bus.retire_cnt);

    // ---- flush together with an incoming ADD
    @(negedge clk);
    we_base = we_count;
    drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, LD_B, 16'h0, 32'h3000);
    bus.flush = 1'b1;
    @(negedge clk);
    idle_in();
    bus.flush = 1'b0;
    #1;
    check("flush_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("flush_rf_we", 32'(bus.rf_we), 32'd0);
    check("flush_retire_cnt", bus.retire_cnt, model_cnt);
    $display("txn flushed ADD wb_valid=%b cnt=%h", bus.wb_valid, bus.retire_cnt);

    // ---- flush beats stall while a load sits in HELD
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h0000_0600, 1'b1, LD_W, 16'h0, 32'h3004);
    bus.sram_rd_data = 32'h0;
    @(negedge clk);
    idle_in();
    bus.stall = 1'b1;
    bus.sram_rd_data = 32'h55AA_55AA;
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check("held_wb_valid", 32'(bus.wb_valid), 32'd1);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    #1;
    check("flush_held_valid", 32'(bus.wb_valid), 32'd0);
    check("flush_held_rf_we", 32'(bus.rf_we), 32'd0);
    @(negedge clk);
    #1;
    check("flush_held_cnt", bus.retire_cnt, model_cnt);
    check("flush_we_pulses", 32'(we_count - we_base), 32'd0);
    $display("txn flushed HELD load cnt=%h", bus.retire_cnt);

    // ---- retire counter wrap
    @(negedge clk);
    force dut.retire_cnt_reg = 32'hFFFF_FFFF;
    drive(1'b1, 5'd3, 32'h0000_0011, 1'b0, LD_B, 16'h0, 32'h4000);
    #1;
    release dut.retire_cnt_reg;
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h0000_0022, 1'b0, LD_B, 16'h0, 32'h4004);
    @(negedge clk);
    idle_in();
    #1;
    check("wrap_cnt0", bus.retire_cnt, 32'h0000_0000);
    @(negedge clk);
    #1;
    check("wrap_cnt1", bus.retire_cnt, 32'h0000_0001);
    $display("txn wrap cnt=%h", bus.retire_cnt);

    // ---- reset while HELD, then a fresh load
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h0000_0600, 1'b1, LD_W, 16'h0, 32'h5000);
    bus.sram_rd_data = 32'h0;
    @(negedge clk);
    idle_in();
    bus.stall = 1'b1;
    bus.sram_rd_data = 32'h1111_1111;
    @(negedge clk);
    bus.sram_rd_data = 32'h2222_2222;
    #1;
    check("prerst_held_wdata", bus.rf_wdata, 32'h1111_1111);
    we_base = we_count;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.stall = 1'b0;
    drive(1'b1, 5'd4, 32'h0000_0700, 1'b1, LD_W, 16'h0, 32'h6000);
    #1;
    check("rstheld_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rstheld_rf_we", 32'(bus.rf_we), 32'd0);
    check("rstheld_rf_wdata", bus.rf_wdata, 32'd0);
    check("rstheld_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rstheld_wb_pc", bus.wb_pc, 32'd0);
    check("rstheld_except", 32'(bus.wb_except_type), 32'd0);
    check("rstheld_retire_cnt", bus.retire_cnt, 32'd0);
    check("rstheld_we_pulses", 32'(we_count - we_base), 32'd0);
    @(negedge clk);
    idle_in();
    bus.sram_rd_data = 32'hCAFE_F00D;
    #1;
    check("fresh_rf_we", 32'(bus.rf_we), 32'd1);
    check("fresh_wdata", bus.rf_wdata, 32'hCAFE_F00D);
    check("fresh_waddr", 32'(bus.rf_waddr), 32'd4);
    @(negedge clk);
    #1;
    check("fresh_retire_cnt", bus.retire_cnt, 32'd1);
    $display("txn post-reset load wdata=%h cnt=%h", bus.rf_wdata, bus.retire_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
